// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg : shared width, saturation limits and FSM encoding for the
//              neuron pre-activation accumulator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package neuron_pkg;

    localparam int DW = 18;

    localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/neuron_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// neuron_accum_ctrl_if : start/bias, product stream and result handshake
//                        of the neuron accumulator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface neuron_accum_ctrl_if #(
    parameter int DW = neuron_pkg::DW
);
    logic                 start;
    logic signed [DW-1:0] bias;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_sat;
    logic                 out_ready;
    logic                 busy;

    modport slave (
        input  start, bias, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );

    modport master (
        output start, bias, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

`default_nettype wire

// File: rtl/neuron_sat_adder.sv
// ---------------------------------------------------------------------------
// neuron_sat_adder : combinational signed add with clamp to DW bits and an
//                    overflow indication.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module neuron_sat_adder #(
    parameter int DW = neuron_pkg::DW
) (
    input  wire logic signed [DW-1:0] i_a,
    input  wire logic signed [DW-1:0] i_b,
    output logic signed [DW-1:0]      o_sum,
    output logic                      o_ovf
);

    localparam logic signed [DW-1:0] c_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] c_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [DW:0] w_sum;
    logic        w_pos_ovf;
    logic        w_neg_ovf;

    assign w_sum = {i_a[DW-1], i_a} + {i_b[DW-1], i_b};

    // The two top bits of the extended sum disagree only when it left range.
    assign w_pos_ovf = ~w_sum[DW] &  w_sum[DW-1];
    assign w_neg_ovf =  w_sum[DW] & ~w_sum[DW-1];

    always_comb begin
        if (w_pos_ovf) begin
            o_sum = c_MAX;
        end else if (w_neg_ovf) begin
            o_sum = c_MIN;
        end else begin
            o_sum = w_sum[DW-1:0];
        end
    end

    assign o_ovf = w_pos_ovf | w_neg_ovf;

endmodule

`default_nettype wire

// File: rtl/neuron_accum_ctrl.sv
// ---------------------------------------------------------------------------
// neuron_accum_ctrl : bias + NUM_INPUTS serial products through one shared
//                     saturating adder. NEURON_ACCUM_RELU_EN clamps the
//                     presented result at zero.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module neuron_accum_ctrl #(
    parameter int NUM_INPUTS = 784,
    parameter int DW         = neuron_pkg::DW
) (
    input wire logic          clk,
    input wire logic          rst,
    neuron_accum_ctrl_if.slave bus
);
    import neuron_pkg::*;

    localparam int             CW     = $clog2(NUM_INPUTS + 1);
    localparam logic [CW-1:0]  c_LAST = CW'(NUM_INPUTS - 1);

    state_t               r_state;
    logic signed [DW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_sat;
    logic                 r_in_ready;

    logic signed [DW-1:0] w_sum;
    logic                 w_ovf;
    logic                 w_in_hs;

    neuron_sat_adder #(
        .DW (DW)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (bus.in_data),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign w_in_hs = r_in_ready & bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc      <= bus.bias;
                        r_cnt      <= '0;
                        r_sat      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_in_hs) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (r_cnt == c_LAST) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_sat   = r_sat;
    assign bus.busy      = (r_state != ST_IDLE);

`ifdef NEURON_ACCUM_RELU_EN
    // Only the presented value is rectified; the accumulator keeps its sign.
    assign bus.out_data = r_acc[DW-1] ? '0 : r_acc;
`else
    assign bus.out_data = r_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_neuron_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_neuron_accum_ctrl : directed and random neurons against a sum-and-clamp
//                        reference; a second instance covers NUM_INPUTS=1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_neuron_accum_ctrl;

    localparam int N    = 4;
    localparam int DW   = 18;
    localparam int VMAX = 131071;
    localparam int VMIN = -131072;

    typedef struct {
        int d;
        int s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    int   prod[N];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    neuron_accum_ctrl_if #(.DW(DW)) bus  ();
    neuron_accum_ctrl_if #(.DW(DW)) bus1 ();

    neuron_accum_ctrl #(.NUM_INPUTS(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    neuron_accum_ctrl #(.NUM_INPUTS(1), .DW(DW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer running sum, clamped after every addition.
    function automatic void model(input int bias, output int rd, output int rs);
        int a;
        int s;
        a  = bias;
        rs = 0;
        for (int i = 0; i < N; i++) begin
            s = a + prod[i];
            if (s > VMAX) begin
                s  = VMAX;
                rs = 1;
            end else if (s < VMIN) begin
                s  = VMIN;
                rs = 1;
            end
            a = s;
        end
`ifdef NEURON_ACCUM_RELU_EN
        if (a < 0) a = 0;
`endif
        rd = a;
    endfunction

    always @(negedge clk) begin
        if (cmp_en && !rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                chk("out_data", int'(bus.out_data), exp_q[0].d);
                chk("out_sat", int'(bus.out_sat), exp_q[0].s);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // vprob < 0 selects an alternating in_valid pattern.
    task automatic run_neuron(input int bias, input int vprob, input int hold,
                              input bit lit, input int ed, input int es,
                              input bit poke_start);
        int i;
        int cyc;
        int rd;
        int rs;
        bit hs;
        i   = 0;
        cyc = 0;
        if (lit) begin
            rd = ed;
            rs = es;
        end else begin
            model(bias, rd, rs);
        end
        exp_q.push_back('{rd, rs});

        bus.start = 1'b1;
        bus.bias  = DW'(bias);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("in_ready_after_start", int'(bus.in_ready), 1);
        chk("busy_in_accum", int'(bus.busy), 1);

        while (i < N && cyc < 200) begin
            if (vprob < 0) bus.in_valid = (cyc % 2 == 0);
            else           bus.in_valid = ($urandom_range(99) < vprob);
            bus.in_data = DW'(prod[i]);
            if (poke_start && cyc == 1) bus.start = 1'b1;
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (hs) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("product_timeout", int'(i), N);
        if (vprob >= 100) chk("accum_cycles", cyc, N);
        chk("out_valid_latency", int'(bus.out_valid), 1);
        chk("in_ready_in_done", int'(bus.in_ready), 0);

        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke_start && k == 0) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("held_out_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("busy_after_out_hs", int'(bus.busy), 0);
        chk("out_valid_after_out_hs", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk("idle_holds", int'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int rs;
        bus.start = 0; bus.bias = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        bus1.start = 0; bus1.bias = '0; bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_busy", int'(bus.busy), 0);
        cmp_en = 1'b1;

        // Pin the reference against hand-computed values.
        prod = '{50, 50, -10, 0};
        model(131000, rd, rs);
        chk("model_pin_sat", rd, 131061);
        chk("model_pin_sat_flag", rs, 1);

        // Basic.
        prod = '{1, 2, 3, 4};
        run_neuron(10, 100, 0, 1'b1, 20, 0, 1'b0);

        // Positive saturation.
        prod = '{50, 50, -10, 0};
        run_neuron(131000, 100, 1, 1'b1, 131061, 1, 1'b0);

        // Negative sum.
        prod = '{-1, -1, -1, -1};
`ifdef NEURON_ACCUM_RELU_EN
        run_neuron(-100, 100, 0, 1'b1, 0, 0, 1'b0);
`else
        run_neuron(-100, 100, 0, 1'b1, -104, 0, 1'b0);
`endif

        // Stalls, held result and ignored start pulses.
        prod = '{5, -3, 7, 1};
        run_neuron(1000, -1, 3, 1'b1, 1010, 0, 1'b1);

        // Negative saturation.
        prod = '{-131072, -131072, 5, 0};
`ifdef NEURON_ACCUM_RELU_EN
        run_neuron(-10, 100, 0, 1'b1, 0, 1, 1'b0);
`else
        run_neuron(-10, 100, 0, 1'b1, -131067, 1, 1'b0);
`endif

        // Abort mid-operation.
        prod = '{7, 8, 9, 10};
        bus.start = 1'b1;
        bus.bias  = DW'(50);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.in_data = DW'(prod[k]);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", int'(bus.in_ready), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_out_data", int'(bus.out_data), 0);
        chk("abort_out_sat", int'(bus.out_sat), 0);
        chk("abort_busy", int'(bus.busy), 0);
        prod = '{1, 1, 1, 1};
        run_neuron(0, 100, 0, 1'b1, 4, 0, 1'b0);

        // Random neurons checked against the reference.
        for (int t = 0; t < 30; t++) begin
            int b;
            if ($urandom_range(1) == 1) b = int'($urandom_range(262143)) - 131072;
            else                        b = int'($urandom_range(2000)) - 1000;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) prod[k] = int'($urandom_range(262143)) - 131072;
                else                        prod[k] = int'($urandom_range(20000)) - 10000;
            end
            run_neuron(b, int'($urandom_range(100, 30)), int'($urandom_range(3)),
                       1'b0, 0, 0, 1'($urandom_range(1)));
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        // NUM_INPUTS=1 instance.
        bus1.start = 1'b1;
        bus1.bias  = DW'(-131072);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        chk("n1_in_ready", int'(bus1.in_ready), 1);
        chk("n1_out_valid_early", int'(bus1.out_valid), 0);
        bus1.in_valid = 1'b1;
        bus1.in_data  = DW'(-5);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("n1_out_valid", int'(bus1.out_valid), 1);
`ifdef NEURON_ACCUM_RELU_EN
        chk("n1_out_data", int'(bus1.out_data), 0);
`else
        chk("n1_out_data", int'(bus1.out_data), -131072);
`endif
        chk("n1_out_sat", int'(bus1.out_sat), 1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("n1_busy_after", int'(bus1.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
